qq_host_driver: RTL and testbench
=================================

# qq_host_driver

Command-side initiator for the QuickQ priority queue. It accepts ENQ/DEQ/CLEAR commands over a valid/ready interface and drives single-cycle `enq`/`deq`/`clr` pulses with a key into the queue's control node. It waits the queue's fixed operation latency, captures the dequeued key, and returns a response over a second valid/ready interface. It tracks occupancy so that ENQ-when-full and DEQ-when-empty are rejected before they reach the queue.

## Interface
Parameters:
- `KEY_W`, 16, key/result width
- `DEPTH`, 16, queue capacity in entries
- `OP_LAT`, 2, cycles from a queue pulse to a valid `q_result`; must be ≥1
- `CNT_W`, $clog2(DEPTH+1), occupancy width (derived, not overridden)

Ports:
- `clk`  input  1  single clock; all logic on its rising edge
- `rst`  input  1  reset, asynchronous and active-low
- `cmd_valid`  input  1  command present
- `cmd_ready`  output  1  driver can accept a command
- `cmd_op`  input  2  01 ENQ, 10 DEQ, 11 CLEAR, 00 illegal
- `cmd_key`  input  KEY_W  key for ENQ (ignored otherwise)
- `enq`  output  1  one-cycle enqueue pulse to queue
- `deq`  output  1  one-cycle dequeue pulse to queue
- `clr`  output  1  one-cycle clear pulse to queue
- `q_key`  output  KEY_W  key presented with `enq`
- `q_result`  input  KEY_W  queue head/dequeued key
- `rsp_valid`  output  1  response present
- `rsp_ready`  input  1  consumer takes response
- `rsp_key`  output  KEY_W  DEQ: dequeued key; ENQ: enqueued key; CLEAR/error: 0
- `rsp_err`  output  1  command rejected, queue untouched
- `count`  output  CNT_W  current occupancy
- `full`, `empty`  output  1 each  count==DEPTH / count==0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch op and key.
  - Illegal op, ENQ with `full`, or DEQ with `empty`: go to RESP with `rsp_err`=1, `rsp_key`=0. No queue pulse, count unchanged.
  - Otherwise: go to ISSUE.
- ISSUE, exactly one cycle: assert exactly one of `enq`/`deq`/`clr`; `q_key`=latched key (0 for DEQ/CLEAR). Count updates at the end of this cycle: ENQ +1, DEQ −1, CLEAR →0. Then go to WAIT with the wait counter loaded.
- WAIT, OP_LAT cycles: all pulses low, `cmd_ready`=0. At the edge ending the last WAIT cycle:
  - DEQ: `rsp_key` ← `q_result`.
  - ENQ: `rsp_key` ← latched key.
  - CLEAR: `rsp_key` ← 0.
  - `rsp_err` ← 0; go to RESP.
- RESP: `rsp_valid`=1. `rsp_key`/`rsp_err` hold stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Exactly one command is in flight at a time; `cmd_ready`=0 in every state but IDLE.
- Count never wraps: saturation is prevented by the rejection rules, and under-/overflow is unreachable.
- `full`/`empty` are decoded from the registered `count`.

## Timing
- Reset (`rst`=0, any time, asynchronous): state IDLE, `count`=0, `empty`=1, `full`=0. `cmd_ready`, `enq`, `deq`, `clr`, `rsp_valid`, `rsp_err` all 0; `q_key`=0, `rsp_key`=0. An in-flight command is dropped with no response.
- `cmd_ready` is a register. It rises on the first `clk` edge after `rst` deasserts.
- Legal command accepted in cycle 0:
  - Pulse in cycle 1.
  - WAIT in cycles 2..OP_LAT+1.
  - `rsp_valid` first high in cycle OP_LAT+2 (cycle 4 at default).
- Rejected command accepted in cycle 0: `rsp_valid` high in cycle 1.
- `rsp_ready` held high: RESP lasts 1 cycle, IDLE follows, and the next accept is possible one cycle after the response. A legal-command throughput is one per OP_LAT+3 cycles.
- `rsp_ready` low: the response holds indefinitely with no pulses and `cmd_ready`=0.
- `count` changes only on the edge ending ISSUE, never on a rejected command.

## Test plan
- Reset then ENQ 0x0042 accepted in cycle 0 → `enq`=1, `q_key`=0x0042 in cycle 1 only. `count`=1 from cycle 2. `rsp_valid`=1 in cycle 4 with `rsp_key`=0x0042, `rsp_err`=0.
- After that ENQ, DEQ with the queue model driving `q_result`=0x0042 at OP_LAT → `deq` pulse once, `rsp_key`=0x0042, `count`=0, `empty`=1.
- DEQ while `empty` → `rsp_valid` the cycle after accept, `rsp_err`=1, `rsp_key`=0, no `deq` pulse. Repeat with ENQ ×16 then a 17th ENQ → `full`=1 and the 17th is rejected with `count` staying 16.
- CLEAR at `count`=5 → single `clr` pulse, `count`=0 after ISSUE, `rsp_key`=0. Separately, `cmd_op`=00 → rejected with `rsp_err`=1.
- Hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`/`rsp_key` stable, `cmd_ready`=0, no pulses. Release → IDLE next cycle.
- Assert `rst` mid-WAIT of a DEQ → all outputs to reset values immediately, `count`=0, no `rsp_valid`. After release, a fresh ENQ completes normally.

Source files
------------

// File: rtl/qq_host_driver.sv
`default_nettype none
// ============================================================================
// qq_host_driver : command-side initiator for the QuickQ priority queue.
// Revision 1.0
// ============================================================================
module qq_host_driver #(
    parameter int KEY_W  = 16,
    parameter int DEPTH  = 16,
    parameter int OP_LAT = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             enq,
    output logic             deq,
    output logic             clr,
    output logic [KEY_W-1:0] q_key,
    input  logic [KEY_W-1:0] q_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [KEY_W-1:0] rsp_key,
    output logic             rsp_err,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;
    localparam int         WAIT_W = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         op;
    logic [KEY_W-1:0]   key;
    logic [WAIT_W-1:0]  wait_cnt;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op        <= OP_ILL;
            key       <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            enq       <= 1'b0;
            deq       <= 1'b0;
            clr       <= 1'b0;
            q_key     <= '0;
            rsp_valid <= 1'b0;
            rsp_key   <= '0;
            rsp_err   <= 1'b0;
            count     <= '0;
        end else begin
            // Queue pulses are single-cycle; only the accept path raises them.
            enq <= 1'b0;
            deq <= 1'b0;
            clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op        <= cmd_op;
                        key       <= cmd_key;
                        if ((cmd_op == OP_ILL) ||
                            ((cmd_op == OP_ENQ) && full) ||
                            ((cmd_op == OP_DEQ) && empty)) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_key   <= '0;
                            state     <= S_RESP;
                        end else begin
                            enq   <= (cmd_op == OP_ENQ);
                            deq   <= (cmd_op == OP_DEQ);
                            clr   <= (cmd_op == OP_CLR);
                            q_key <= (cmd_op == OP_ENQ) ? cmd_key : '0;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    q_key <= '0;
                    case (op)
                        OP_ENQ:  count <= count + CNT_W'(1);
                        OP_DEQ:  count <= count - CNT_W'(1);
                        default: count <= '0;
                    endcase
                    wait_cnt <= WAIT_W'(OP_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        case (op)
                            OP_DEQ:  rsp_key <= q_result;
                            OP_ENQ:  rsp_key <= key;
                            default: rsp_key <= '0;
                        endcase
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qq_host_driver.sv
`default_nettype none
// ============================================================================
// tb_qq_host_driver : directed self-checking bench for qq_host_driver.
// Revision 1.0
// ============================================================================
module tb_qq_host_driver;

    localparam logic [15:0] DEAD   = 16'hDEAD;
    localparam logic [1:0]  OP_ENQ = 2'b01;
    localparam logic [1:0]  OP_DEQ = 2'b10;
    localparam logic [1:0]  OP_CLR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_key = 16'h0;
    logic        enq, deq, clr;
    logic [15:0] q_key;
    logic [15:0] q_result = DEAD;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_key;
    logic        rsp_err;
    logic [4:0]  count;
    logic        full, empty;

    int total = 0;
    int bad   = 0;

    qq_host_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_key   (cmd_key),
        .enq       (enq),
        .deq       (deq),
        .clr       (clr),
        .q_key     (q_key),
        .q_result  (q_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_key   (rsp_key),
        .rsp_err   (rsp_err),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Legal command accepted in the current cycle; returns in the first RESP cycle.
    task automatic legal(input logic [1:0] op, input logic [15:0] key,
                         input logic [2:0] pulses, input logic [15:0] qk,
                         input logic [4:0] cnt, input logic [15:0] qv,
                         input logic [15:0] rkey);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_key = 16'h0;
        chk("pulse_c1", {enq, deq, clr}, pulses);
        chk("qkey_c1", q_key, qk);
        chk("ready_c1", cmd_ready, 0);
        @(negedge clk);
        chk("pulse_c2", {enq, deq, clr}, 0);
        chk("qkey_c2", q_key, 0);
        chk("count_c2", count, cnt);
        chk("rvalid_c2", rsp_valid, 0);
        @(negedge clk);
        q_result = qv;
        chk("rvalid_c3", rsp_valid, 0);
        chk("pulse_c3", {enq, deq, clr}, 0);
        @(negedge clk);
        q_result = DEAD;
        chk("rvalid_c4", rsp_valid, 1);
        chk("rkey_c4", rsp_key, rkey);
        chk("rerr_c4", rsp_err, 0);
        chk("count_c4", count, cnt);
    endtask

    task automatic drain();
        @(negedge clk);
        chk("rvalid_drained", rsp_valid, 0);
        chk("ready_after_rsp", cmd_ready, 1);
    endtask

    task automatic reject(input logic [1:0] op, input logic [15:0] key, input logic [4:0] cnt);
        chk("ready_idle_rej", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_key = 16'h0;
        chk("rej_rvalid", rsp_valid, 1);
        chk("rej_err", rsp_err, 1);
        chk("rej_key", rsp_key, 0);
        chk("rej_pulse", {enq, deq, clr}, 0);
        chk("rej_count", count, cnt);
        drain();
        chk("rej_count_after", count, cnt);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_outs", {enq, deq, clr, rsp_valid, rsp_err}, 0);
        chk("rst_qkey", q_key, 0);
        chk("rst_rkey", rsp_key, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_rise", cmd_ready, 1);

        // ENQ then DEQ of 0x0042
        legal(OP_ENQ, 16'h0042, 3'b100, 16'h0042, 5'd1, DEAD, 16'h0042);
        drain();
        legal(OP_DEQ, 16'h1234, 3'b010, 16'h0000, 5'd0, 16'h0042, 16'h0042);
        drain();
        chk("empty_after_deq", empty, 1);

        // DEQ when empty
        reject(OP_DEQ, 16'h0000, 5'd0);

        // Fill to DEPTH, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            legal(OP_ENQ, 16'h0100 + 16'(i), 3'b100, 16'h0100 + 16'(i),
                  5'(i + 1), DEAD, 16'h0100 + 16'(i));
            drain();
        end
        chk("full_16", full, 1);
        chk("empty_16", empty, 0);
        reject(OP_ENQ, 16'h0077, 5'd16);
        chk("full_still", full, 1);

        // CLEAR at count 5
        legal(OP_CLR, 16'hBEEF, 3'b001, 16'h0000, 5'd0, DEAD, 16'h0000);
        drain();
        for (int i = 0; i < 5; i++) begin
            legal(OP_ENQ, 16'h0200 + 16'(i), 3'b100, 16'h0200 + 16'(i),
                  5'(i + 1), DEAD, 16'h0200 + 16'(i));
            drain();
        end
        legal(OP_CLR, 16'h5555, 3'b001, 16'h0000, 5'd0, DEAD, 16'h0000);
        drain();
        chk("empty_after_clr", empty, 1);

        // Illegal opcode
        reject(2'b00, 16'h1111, 5'd0);

        // Backpressure on the response
        rsp_ready = 1'b0;
        legal(OP_ENQ, 16'hA5A5, 3'b100, 16'hA5A5, 5'd1, DEAD, 16'hA5A5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rvalid", rsp_valid, 1);
            chk("hold_rkey", rsp_key, 16'hA5A5);
            chk("hold_ready", cmd_ready, 0);
            chk("hold_pulse", {enq, deq, clr}, 0);
        end
        rsp_ready = 1'b1;
        drain();

        // Reset in the middle of a DEQ's wait
        chk("ready_pre_deq", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = OP_DEQ;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'b00;
        chk("mid_deq_pulse", {enq, deq, clr}, 3'b010);
        @(negedge clk);
        chk("mid_count", count, 0);
        rst = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_ready", cmd_ready, 0);
        chk("async_outs", {enq, deq, clr, rsp_valid, rsp_err}, 0);
        @(negedge clk);
        chk("rst_hold_rvalid", rsp_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rerelease_ready", cmd_ready, 1);
        chk("rerelease_rvalid", rsp_valid, 0);
        legal(OP_ENQ, 16'h0BAD, 3'b100, 16'h0BAD, 5'd1, DEAD, 16'h0BAD);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
